// File: rtl/cordic_iter_state_reg.sv
// rtl/cordic_iter_state_reg.sv - x/y/z and iteration-index register bank for the iterative CORDIC core
module cordic_iter_state_reg #(
   parameter int WIDTH = 16,
   parameter int ITERS = 16,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             ack,
   input  logic [WIDTH-1:0] x0,
   input  logic [WIDTH-1:0] y0,
   input  logic [WIDTH-1:0] z0,
   input  logic [WIDTH-1:0] x_nxt,
   input  logic [WIDTH-1:0] y_nxt,
   input  logic [WIDTH-1:0] z_nxt,
   output logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] z,
   output logic [CNT_W-1:0] iter,
   output logic             busy,
   output logic             done
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Index of the final micro-rotation; reaching it ends the operation.
   localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(ITERS - 1);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [CNT_W-1:0] iter_nxt;
   logic             load;
   logic             capture;

   // Next-state decode: load on accepted start, capture on every non-aborted RUN cycle.
   always_comb begin
      state_nxt = state;
      iter_nxt  = iter;
      load      = 1'b0;
      capture   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               load      = 1'b1;
               iter_nxt  = '0;
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (abort) begin
               iter_nxt  = '0;
               state_nxt = S_IDLE;
            end else begin
               capture = 1'b1;
               if (iter == ITER_LAST) begin
                  iter_nxt  = '0;
                  state_nxt = S_DONE;
               end else begin
                  iter_nxt = iter + CNT_W'(1);
               end
            end
         end
         S_DONE: begin
            if (start) begin
               load      = 1'b1;
               iter_nxt  = '0;
               state_nxt = S_RUN;
            end else if (ack) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            iter_nxt  = '0;
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Control registers; busy/done are flopped copies of the next-state decode so they stay glitch-free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         iter  <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         iter  <= iter_nxt;
         busy  <= (state_nxt == S_RUN);
         done  <= (state_nxt == S_DONE);
      end
   end

   // Vector registers: operands on load, rotation-stage outputs on capture, otherwise hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x <= '0;
         y <= '0;
         z <= '0;
      end else if (load) begin
         x <= x0;
         y <= y0;
         z <= z0;
      end else if (capture) begin
         x <= x_nxt;
         y <= y_nxt;
         z <= z_nxt;
      end
   end

endmodule

// File: tb/tb_cordic_iter_state_reg.sv
// tb/tb_cordic_iter_state_reg.sv - directed bench for cordic_iter_state_reg (ITERS=4 and ITERS=1)
module tb_cordic_iter_state_reg;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   // ITERS=4 instance
   logic        start = 1'b0, abort = 1'b0, ack = 1'b0;
   logic [15:0] x0 = '0, y0 = '0, z0 = '0;
   logic [15:0] x_nxt, y_nxt, z_nxt, x, y, z;
   logic [3:0]  iter;
   logic        busy, done;

   // ITERS=1 instance
   logic        start1 = 1'b0, abort1 = 1'b0, ack1 = 1'b0;
   logic [15:0] x01 = '0, y01 = '0, z01 = '0;
   logic [15:0] x_nxt1, y_nxt1, z_nxt1, x1, y1, z1;
   logic [3:0]  iter1;
   logic        busy1, done1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // Rotation-stage stub: next = current + 1.
   assign x_nxt  = x + 16'd1;
   assign y_nxt  = y + 16'd1;
   assign z_nxt  = z + 16'd1;
   assign x_nxt1 = x1 + 16'd1;
   assign y_nxt1 = y1 + 16'd1;
   assign z_nxt1 = z1 + 16'd1;

   cordic_iter_state_reg #(.WIDTH(16), .ITERS(4), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .ack(ack),
      .x0(x0), .y0(y0), .z0(z0), .x_nxt(x_nxt), .y_nxt(y_nxt), .z_nxt(z_nxt),
      .x(x), .y(y), .z(z), .iter(iter), .busy(busy), .done(done)
   );

   cordic_iter_state_reg #(.WIDTH(16), .ITERS(1), .CNT_W(4)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .abort(abort1), .ack(ack1),
      .x0(x01), .y0(y01), .z0(z01), .x_nxt(x_nxt1), .y_nxt(y_nxt1), .z_nxt(z_nxt1),
      .x(x1), .y(y1), .z(z1), .iter(iter1), .busy(busy1), .done(done1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset state
      #2;
      check("rst_x", 32'(x), 32'h0);
      check("rst_y", 32'(y), 32'h0);
      check("rst_z", 32'(z), 32'h0);
      check("rst_iter", 32'(iter), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      tick();
      rst = 1'b0;
      tick();

      // nominal run; start held high through RUN must be ignored
      x0 = 16'h0010; y0 = 16'h0020; z0 = 16'h0030; start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("run_busy", 32'(busy), 32'h1);
         check("run_done", 32'(done), 32'h0);
         check("run_iter", 32'(iter), 32'(i));
         check("run_x", 32'(x), 32'h10 + 32'(i));
      end
      start = 1'b0;
      tick();
      check("res_done", 32'(done), 32'h1);
      check("res_busy", 32'(busy), 32'h0);
      check("res_iter", 32'(iter), 32'h0);
      check("res_x", 32'(x), 32'h0014);
      check("res_y", 32'(y), 32'h0024);
      check("res_z", 32'(z), 32'h0034);

      // hold in DONE without ack; abort ignored
      abort = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      abort = 1'b0;
      check("hold_done", 32'(done), 32'h1);
      check("hold_x", 32'(x), 32'h0014);
      check("hold_z", 32'(z), 32'h0034);

      // ack returns to IDLE, values kept
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("ack_done", 32'(done), 32'h0);
      check("ack_busy", 32'(busy), 32'h0);
      check("ack_x", 32'(x), 32'h0014);
      check("ack_y", 32'(y), 32'h0024);
      tick();
      check("idle_x", 32'(x), 32'h0014);

      // abort at iter=2
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("pre_abort_iter", 32'(iter), 32'h2);
      check("pre_abort_x", 32'(x), 32'h0012);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", 32'(busy), 32'h0);
      check("abort_iter", 32'(iter), 32'h0);
      check("abort_x", 32'(x), 32'h0012);
      check("abort_done", 32'(done), 32'h0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("abort_no_done", 32'(done), 32'h0);
      end

      // back-to-back: start and ack together in DONE
      x0 = 16'h0010;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("b2b_first_done", 32'(done), 32'h1);
      check("b2b_first_x", 32'(x), 32'h0014);
      x0 = 16'h0100; start = 1'b1; ack = 1'b1;
      tick();
      start = 1'b0; ack = 1'b0;
      check("b2b_x", 32'(x), 32'h0100);
      check("b2b_done", 32'(done), 32'h0);
      check("b2b_busy", 32'(busy), 32'h1);
      for (int i = 0; i < 4; i++) tick();
      check("b2b_second_done", 32'(done), 32'h1);
      check("b2b_second_x", 32'(x), 32'h0104);
      ack = 1'b1;
      tick();
      ack = 1'b0;

      // asynchronous reset between edges during RUN
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("pre_rst_iter", 32'(iter), 32'h1);
      #2;
      rst = 1'b1;
      start = 1'b1;
      #1;
      check("arst_x", 32'(x), 32'h0);
      check("arst_y", 32'(y), 32'h0);
      check("arst_z", 32'(z), 32'h0);
      check("arst_iter", 32'(iter), 32'h0);
      check("arst_busy", 32'(busy), 32'h0);
      tick();
      check("arst_start_ignored", 32'(busy), 32'h0);
      start = 1'b0;
      rst = 1'b0;
      tick();
      check("post_rst_busy", 32'(busy), 32'h0);
      check("post_rst_x", 32'(x), 32'h0);

      // ITERS=1 instance
      x01 = 16'h0005; y01 = 16'h0007; z01 = 16'h0009; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      check("i1_busy", 32'(busy1), 32'h1);
      check("i1_iter", 32'(iter1), 32'h0);
      check("i1_x_load", 32'(x1), 32'h0005);
      tick();
      check("i1_done", 32'(done1), 32'h1);
      check("i1_busy_low", 32'(busy1), 32'h0);
      check("i1_x", 32'(x1), 32'h0006);
      check("i1_z", 32'(z1), 32'h000a);
      check("i1_iter_done", 32'(iter1), 32'h0);
      ack1 = 1'b1;
      tick();
      ack1 = 1'b0;
      check("i1_ack_done", 32'(done1), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
